reg_writeback_ctrl: RTL and testbench
=====================================

# reg_writeback_ctrl

Write-side controller for the processor's 32x32 register file. It merges ALU results and out-of-order-latency load results into the file's single write port, at most one write per cycle. It buffers load returns in a small FIFO and keeps a per-register pending-load scoreboard so decode can stall on registers whose load has not yet been written. It sits between the execute/memory stages and the register file's RegWrite/write-address/writeData inputs.

## Interface
- LOAD_FIFO_DEPTH, 4, load-return buffer entries (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive cycles ALU may block a non-empty load FIFO before loads are forced

- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- AluValid  in  1  ALU result present
- AluDest  in  5  ALU destination register
- AluData  in  32  ALU result
- AluReady  out  1  ALU result accepted this cycle when AluValid && AluReady
- LoadIssue  in  1  a load to LoadIssueDest was issued this cycle
- LoadIssueDest  in  5  destination of the issued load
- LoadValid  in  1  load data returning
- LoadDest  in  5  returning load destination
- LoadData  in  32  returning load data
- LoadReady  out  1  FIFO not full; transfer on LoadValid && LoadReady
- RegWrite  out  1  registered write enable to register file
- WriteReg  out  5  registered write address
- WriteData  out  32  registered write data
- QueryReg1, QueryReg2  in  5 each  decode source registers
- Busy1, Busy2  out  1 each  combinational stall flags for the query registers
- Pending  out  32  scoreboard, bit r set = load to r outstanding

## Operation
- Reset state: FIFO empty, Pending=0, RegWrite=0, WriteReg=0, WriteData=0, starve counter=0. AluReady=1 and LoadReady=1 while in reset and immediately after.
- LoadReady = FIFO not full (combinational).
- Arbitration each cycle picks one source for the output register:
  - ALU, if AluValid && AluReady.
  - Else FIFO head, if FIFO not empty.
  - Else none; RegWrite goes 0 at the next edge.
- AluReady = !(FIFO non-empty && starve counter == STARVE_LIMIT).
- Starve counter:
  - Increments on each edge where the ALU wins while the FIFO is non-empty.
  - Resets to 0 when the FIFO head is written or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Scoreboard:
  - LoadIssue sets Pending[LoadIssueDest].
  - A FIFO head moving into the output register clears Pending[its dest].
  - If set and clear hit the same register on the same edge, set wins.
  - ALU writes never modify Pending.
- Busy_k = Pending[QueryReg_k] | (RegWrite && WriteReg == QueryReg_k). This covers the cycle in which the register file has not yet committed the write.
- Register 0 is an ordinary register; there is no write suppression.
- A load enqueued into a full FIFO is impossible by the handshake. LoadValid with LoadReady=0 holds; the source keeps LoadDest/LoadData stable.
- FIFO simultaneous push and pop when full: push is refused (LoadReady=0). When empty, push occurs and pop does not, because the head is not yet valid.

## Timing
- ALU accepted at edge N: RegWrite=1, WriteReg=AluDest, WriteData=AluData during cycle N..N+1. The register file commits at edge N+1.
- Load accepted at edge N enters the FIFO; the earliest output-register load is at edge N+1. RegWrite is high in cycle N+1..N+2. Minimum latency is 2 edges from acceptance to register-file commit.
- FIFO order is strictly first-in first-out; loads are written in return order.
- Throughput: one write per cycle. Sustained ALU traffic guarantees one load write every STARVE_LIMIT+1 cycles.
- Reset asserted mid-operation drops buffered loads, clears Pending, and deasserts RegWrite asynchronously with no partial write.

## Test plan
- Reset then idle: RegWrite=0, Pending=0, LoadReady=1, AluReady=1. Busy1=Busy2=0 for all query values.
- ALU write AluDest=5, AluData=0xDEADBEEF at edge N → RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF in the next cycle. Busy1=1 for QueryReg1=5 in that cycle only.
- LoadIssue dest=7, later LoadValid dest=7 data=0x1234 with ALU idle:
  - Pending[7]=1 from issue until the head moves out.
  - RegWrite to r7 occurs 2 edges after acceptance.
  - Pending[7]=0 one edge earlier than the commit; Busy stays 1 through the commit cycle.
- AluValid held high, four loads returned: FIFO fills, LoadReady=0 on the 5th. After 8 ALU wins, AluReady=0 for one cycle and load 1 is written; pattern repeats.
- Same-edge LoadIssue dest=3 and FIFO head dest=3 written: Pending[3] remains 1.
- Reset pulsed between edges with 3 loads buffered and RegWrite=1: outputs go to 0 without a clock edge, FIFO empty, and no stale writes after release.

Source files
------------

// File: rtl/reg_writeback_ctrl.sv
// Purpose : merges ALU results and buffered load returns into the single register-file
//           write port (one write per cycle) and tracks outstanding loads per register.
// Latency : ALU result reaches the write port 1 edge after acceptance; a load 2 edges.
// Backpressure: LoadReady drops while the load FIFO is full. AluReady drops for one cycle
//           after STARVE_LIMIT ALU wins against a waiting load, so the FIFO head can drain.
//
// Ports:
//   Clk, Reset                  clock, asynchronous active-high reset
//   AluValid/AluDest/AluData    ALU result in, accepted when AluValid && AluReady
//   LoadIssue/LoadIssueDest     load issued this cycle; sets the pending bit
//   LoadValid/LoadDest/LoadData load return in, accepted when LoadValid && LoadReady
//   RegWrite/WriteReg/WriteData registered register-file write port
//   QueryReg1/2, Busy1/2        decode stall lookup (combinational)
//   Pending                     per-register outstanding-load scoreboard
module reg_writeback_ctrl #(
  parameter int LOAD_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        AluValid,
  input  logic [4:0]  AluDest,
  input  logic [31:0] AluData,
  output logic        AluReady,
  input  logic        LoadIssue,
  input  logic [4:0]  LoadIssueDest,
  input  logic        LoadValid,
  input  logic [4:0]  LoadDest,
  input  logic [31:0] LoadData,
  output logic        LoadReady,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  input  logic [4:0]  QueryReg1,
  input  logic [4:0]  QueryReg2,
  output logic        Busy1,
  output logic        Busy2,
  output logic [31:0] Pending
);

  localparam int AW = (LOAD_FIFO_DEPTH > 1) ? $clog2(LOAD_FIFO_DEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(LOAD_FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Load-return buffer. Storage is not reset; only pointers/count are, so a
  // reset empties the FIFO without touching the arrays.
  logic [4:0]    fifo_dest [LOAD_FIFO_DEPTH];
  logic [31:0]   fifo_data [LOAD_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [SW-1:0] starve_cnt;
  logic [31:0]   pending_q;
  logic [31:0]   pending_nxt;

  logic fifo_empty;
  logic fifo_full;
  logic alu_win;
  logic push;
  logic pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);

  assign LoadReady = !fifo_full;
  assign AluReady  = !(!fifo_empty && (starve_cnt == STARVE_MAX));

  // ALU has priority; the FIFO head goes out whenever the ALU does not.
  // A push into an empty FIFO is not poppable in the same cycle because
  // pop is qualified on the pre-edge count.
  assign alu_win = AluValid && AluReady;
  assign push    = LoadValid && !fifo_full;
  assign pop     = !alu_win && !fifo_empty;

  // Clear for the departing head is applied first so a same-edge issue to
  // the same register leaves the bit set.
  always_comb begin
    pending_nxt = pending_q;
    if (pop) begin
      pending_nxt[fifo_dest[rd_ptr]] = 1'b0;
    end
    if (LoadIssue) begin
      pending_nxt[LoadIssueDest] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_dest[wr_ptr] <= LoadDest;
      fifo_data[wr_ptr] <= LoadData;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Counts ALU wins while a load waits; restarts once a load drains or the
  // FIFO is empty, and holds at the limit until the forced load goes out.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      starve_cnt <= '0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (alu_win && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_nxt;
    end
  end

  // Write port register. Address/data hold when idle; only RegWrite drops.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (alu_win) begin
      RegWrite  <= 1'b1;
      WriteReg  <= AluDest;
      WriteData <= AluData;
    end else if (pop) begin
      RegWrite  <= 1'b1;
      WriteReg  <= fifo_dest[rd_ptr];
      WriteData <= fifo_data[rd_ptr];
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  assign Pending = pending_q;

  // The in-flight write also counts as busy: the register file has not
  // committed it until the following edge.
  assign Busy1 = pending_q[QueryReg1] | (RegWrite && (WriteReg == QueryReg1));
  assign Busy2 = pending_q[QueryReg2] | (RegWrite && (WriteReg == QueryReg2));

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
module tb_reg_writeback_ctrl;

  logic        Clk;
  logic        Reset;
  logic        AluValid;
  logic [4:0]  AluDest;
  logic [31:0] AluData;
  logic        AluReady;
  logic        LoadIssue;
  logic [4:0]  LoadIssueDest;
  logic        LoadValid;
  logic [4:0]  LoadDest;
  logic [31:0] LoadData;
  logic        LoadReady;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  QueryReg1;
  logic [4:0]  QueryReg2;
  logic        Busy1;
  logic        Busy2;
  logic [31:0] Pending;

  int vecs = 0;
  int errs = 0;

  reg_writeback_ctrl #(.LOAD_FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .AluValid(AluValid), .AluDest(AluDest), .AluData(AluData), .AluReady(AluReady),
    .LoadIssue(LoadIssue), .LoadIssueDest(LoadIssueDest),
    .LoadValid(LoadValid), .LoadDest(LoadDest), .LoadData(LoadData), .LoadReady(LoadReady),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .QueryReg1(QueryReg1), .QueryReg2(QueryReg2),
    .Busy1(Busy1), .Busy2(Busy2), .Pending(Pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    AluValid = 1'b0; AluDest = '0; AluData = '0;
    LoadIssue = 1'b0; LoadIssueDest = '0;
    LoadValid = 1'b0; LoadDest = '0; LoadData = '0;
    QueryReg1 = '0; QueryReg2 = '0;

    // ---- reset state ----
    #3;
    check("rst_aluready", AluReady, 1);
    check("rst_loadready", LoadReady, 1);
    check("rst_regwrite", RegWrite, 0);
    check("rst_pending", Pending, 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    check("idle_regwrite", RegWrite, 0);
    check("idle_pending", Pending, 0);
    check("idle_aluready", AluReady, 1);
    check("idle_loadready", LoadReady, 1);
    for (int q = 0; q < 32; q++) begin
      QueryReg1 = 5'(q);
      QueryReg2 = 5'(31 - q);
      #1;
      check("idle_busy1", Busy1, 0);
      check("idle_busy2", Busy2, 0);
    end

    // ---- single ALU write ----
    QueryReg1 = 5'd5; QueryReg2 = 5'd6;
    AluValid = 1'b1; AluDest = 5'd5; AluData = 32'hDEADBEEF;
    #1;
    check("alu_busy_before", Busy1, 0);
    tick();
    AluValid = 1'b0;
    check("alu_regwrite", RegWrite, 1);
    check("alu_writereg", WriteReg, 5);
    check("alu_writedata", WriteData, 32'hDEADBEEF);
    check("alu_busy1", Busy1, 1);
    check("alu_busy2_other", Busy2, 0);
    tick();
    check("alu_regwrite_off", RegWrite, 0);
    check("alu_busy1_after", Busy1, 0);

    // ---- load issue / return to r7 ----
    QueryReg1 = 5'd7;
    LoadIssue = 1'b1; LoadIssueDest = 5'd7;
    tick();
    LoadIssue = 1'b0;
    check("ld_pending_set", Pending, 32'h0000_0080);
    check("ld_busy_pending", Busy1, 1);
    tick();
    check("ld_pending_hold", Pending, 32'h0000_0080);
    LoadValid = 1'b1; LoadDest = 5'd7; LoadData = 32'h1234;
    #1;
    check("ld_loadready", LoadReady, 1);
    tick();  // accepted into FIFO
    LoadValid = 1'b0;
    check("ld_no_write_yet", RegWrite, 0);
    check("ld_pending_in_fifo", Pending, 32'h0000_0080);
    tick();  // head moves to write port
    check("ld_regwrite", RegWrite, 1);
    check("ld_writereg", WriteReg, 7);
    check("ld_writedata", WriteData, 32'h1234);
    check("ld_pending_clear", Pending, 0);
    check("ld_busy_commit_cycle", Busy1, 1);
    tick();
    check("ld_regwrite_off", RegWrite, 0);
    check("ld_busy_after", Busy1, 0);

    // ---- starvation: ALU held, four loads returned ----
    AluValid = 1'b1; AluDest = 5'd1; AluData = 32'h55;
    for (int k = 0; k < 4; k++) begin
      LoadValid = 1'b1; LoadDest = 5'(10 + k); LoadData = 32'hA0 + 32'(k);
      tick();
    end
    LoadValid = 1'b1; LoadDest = 5'd14; LoadData = 32'hA4;
    #1;
    check("st_full_loadready", LoadReady, 0);
    LoadValid = 1'b0;
    // wins against a waiting load so far: 3; five more reach the limit
    for (int k = 0; k < 4; k++) begin
      tick();
      check("st_aluready_early", AluReady, 1);
    end
    tick();
    check("st_aluready_low", AluReady, 0);
    check("st_alu_write", WriteReg, 1);
    tick();
    check("st_forced_writereg", WriteReg, 10);
    check("st_forced_writedata", WriteData, 32'hA0);
    check("st_aluready_back", AluReady, 1);
    check("st_loadready_back", LoadReady, 1);
    for (int k = 0; k < 7; k++) tick();
    check("st_aluready_7wins", AluReady, 1);
    tick();
    check("st_aluready_low2", AluReady, 0);
    tick();
    check("st_forced2_writereg", WriteReg, 11);
    check("st_forced2_writedata", WriteData, 32'hA1);
    AluValid = 1'b0;
    tick();
    check("st_drain_reg12", WriteReg, 12);
    check("st_drain_data12", WriteData, 32'hA2);
    tick();
    check("st_drain_reg13", WriteReg, 13);
    check("st_drain_data13", WriteData, 32'hA3);
    tick();
    check("st_drain_done", RegWrite, 0);
    check("st_pending_zero", Pending, 0);

    // ---- same-edge issue and head write to r3 ----
    LoadIssue = 1'b1; LoadIssueDest = 5'd3;
    tick();
    LoadIssue = 1'b0;
    check("se_pending_set", Pending, 32'h0000_0008);
    LoadValid = 1'b1; LoadDest = 5'd3; LoadData = 32'h33;
    tick();
    LoadValid = 1'b0;
    LoadIssue = 1'b1; LoadIssueDest = 5'd3;
    tick();
    LoadIssue = 1'b0;
    check("se_write_r3", WriteReg, 3);
    check("se_regwrite", RegWrite, 1);
    check("se_pending_kept", Pending, 32'h0000_0008);
    LoadValid = 1'b1; LoadDest = 5'd3; LoadData = 32'h34;
    tick();
    LoadValid = 1'b0;
    tick();
    check("se_pending_cleared", Pending, 0);
    check("se_data2", WriteData, 32'h34);
    tick();

    // ---- asynchronous reset with loads buffered ----
    AluValid = 1'b1; AluDest = 5'd2; AluData = 32'h77;
    LoadIssue = 1'b1; LoadIssueDest = 5'd20;
    for (int k = 0; k < 3; k++) begin
      LoadValid = 1'b1; LoadDest = 5'(24 + k); LoadData = 32'hC0 + 32'(k);
      tick();
      LoadIssue = 1'b0;
    end
    LoadValid = 1'b0; AluValid = 1'b0;
    check("ar_regwrite_pre", RegWrite, 1);
    check("ar_pending_pre", Pending, 32'h0010_0000);
    #1;
    Reset = 1'b1;
    #1;
    check("ar_regwrite", RegWrite, 0);
    check("ar_writereg", WriteReg, 0);
    check("ar_writedata", WriteData, 0);
    check("ar_pending", Pending, 0);
    check("ar_loadready", LoadReady, 1);
    check("ar_aluready", AluReady, 1);
    @(negedge Clk);
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ar_no_stale_write", RegWrite, 0);
    end
    check("ar_writereg_after", WriteReg, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
